ec_mvd_rd: RTL

EC_MVD_RD -- requirements
Module: ec_mvd_rd

---
 rtl/ec_mvd_rd_pkg.sv | 23 ++
 rtl/ec_mvd_rd_if.sv | 60 ++++++
 rtl/ec_mvd_fifo2.sv | 49 ++++
 rtl/ec_mvd_rd.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ec_mvd_rd_pkg.sv
// ec_mvd_rd_pkg -- shared definitions for the mvd buffer reader.
//   state_t     : reader FSM encoding (IDLE / READ / DRAIN)
//   FIFO_DEPTH  : depth of the output skid FIFO
//   X_/Y_ MSB/LSB : bit positions of mvd_x and mvd_y inside a buffer word
//   MAX_NUM     : largest fetch length; larger requests are clamped to it
package ec_mvd_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;

    localparam int X_MSB = 17;
    localparam int X_LSB = 9;
    localparam int Y_MSB = 8;
    localparam int Y_LSB = 0;

    localparam logic [5:0] MAX_NUM = 6'd32;

endpackage

// File: rtl/ec_mvd_rd_if.sv
// ec_mvd_rd_if -- buffer read bus plus mvd output stream of the reader.
//   rd_o / r_addr_o / data_i   : synchronous buffer read (data one cycle after rd_o)
//   mvd_valid_o / mvd_ready_i  : output handshake
//   mvd_x_o, mvd_y_o           : signed mvd components of the head word
//   mvd_idx_o, mvd_last_o      : entry index and final-entry flag
//   mvd_abs_x_o, mvd_abs_y_o   : magnitudes, present only with EC_MVD_ABS_EN
// master = the reader, slave = buffer + consumer side.
interface ec_mvd_rd_if #(
    parameter int AW = 5,
    parameter int DW = 18
);
    logic                 rd_o;
    logic [AW-1:0]        r_addr_o;
    logic [DW-1:0]        data_i;
    logic                 mvd_valid_o;
    logic                 mvd_ready_i;
    logic signed [8:0]    mvd_x_o;
    logic signed [8:0]    mvd_y_o;
    logic [AW-1:0]        mvd_idx_o;
    logic                 mvd_last_o;
`ifdef EC_MVD_ABS_EN
    logic [8:0]           mvd_abs_x_o;
    logic [8:0]           mvd_abs_y_o;

    modport master (
        output rd_o, r_addr_o,
        input  data_i,
        output mvd_valid_o,
        input  mvd_ready_i,
        output mvd_x_o, mvd_y_o, mvd_idx_o, mvd_last_o,
        output mvd_abs_x_o, mvd_abs_y_o
    );

    modport slave (
        input  rd_o, r_addr_o,
        output data_i,
        input  mvd_valid_o,
        output mvd_ready_i,
        input  mvd_x_o, mvd_y_o, mvd_idx_o, mvd_last_o,
        input  mvd_abs_x_o, mvd_abs_y_o
    );
`else
    modport master (
        output rd_o, r_addr_o,
        input  data_i,
        output mvd_valid_o,
        input  mvd_ready_i,
        output mvd_x_o, mvd_y_o, mvd_idx_o, mvd_last_o
    );

    modport slave (
        input  rd_o, r_addr_o,
        output data_i,
        input  mvd_valid_o,
        output mvd_ready_i,
        input  mvd_x_o, mvd_y_o, mvd_idx_o, mvd_last_o
    );
`endif

endinterface

// File: rtl/ec_mvd_fifo2.sv
// ec_mvd_fifo2 -- two-entry FIFO holding fetched mvd entries.
//   clk, rst : clock, asynchronous active-high reset (pointers and count only)
//   push/din : write din at the tail (ignored when full without a pop)
//   pop      : drop the head entry (ignored when empty)
//   count    : number of stored entries, 0..2
//   dout     : head entry, meaningful while count != 0
module ec_mvd_fifo2
    import ec_mvd_rd_pkg::*;
#(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [1:0]   count,
    output logic [W-1:0] dout
);

    logic [W-1:0] mem [FIFO_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count < 2'(FIFO_DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            // push and pop together cancel out
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/ec_mvd_rd.sv
// ec_mvd_rd -- fetches num_i mvd words from a synchronous buffer starting at
// address 0 and streams them out through a valid/ready handshake.
//   clk, rst       : clock, asynchronous active-high reset
//   start_i, num_i : start pulse and entry count (clamped to 32, 0 = no-op)
//   busy_o, done_o : fetch in progress / one-cycle completion pulse
//   bus (master)   : buffer read bus and mvd output stream (ec_mvd_rd_if)
// Optional feature: define EC_MVD_ABS_EN to add saturated |mvd_x|, |mvd_y|
// outputs that travel with each FIFO entry.
module ec_mvd_rd
    import ec_mvd_rd_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [5:0]  num_i,
    output logic        busy_o,
    output logic        done_o,
    ec_mvd_rd_if.master bus
);

    typedef struct packed {
`ifdef EC_MVD_ABS_EN
        logic [8:0]        abs_x;
        logic [8:0]        abs_y;
`endif
        logic              last;
        logic [AW-1:0]     idx;
        logic signed [8:0] x;
        logic signed [8:0] y;
    } entry_t;

    localparam int EW = $bits(entry_t);

`ifdef EC_MVD_ABS_EN
    localparam logic signed [8:0] MVD_MIN = 9'sh100;

    // -256 has no positive 9-bit counterpart, so it saturates to 255
    function automatic logic [8:0] abs_sat(input logic signed [8:0] v);
        if (v == MVD_MIN) return 9'd255;
        else if (v < 0)   return -v;
        else              return v;
    endfunction
`endif

    state_t          state;
    logic [5:0]      num_r;
    logic [5:0]      rd_cnt;
    logic [5:0]      push_cnt;
    logic [5:0]      num_clamped;
    logic [AW-1:0]   addr;
    logic            rd;
    logic            rd_p1;
    logic            push;
    logic            pop;
    logic            valid;
    logic            start_ok;
    logic [1:0]      count;
    logic [2:0]      occ;
    logic [DW-1:0]   word;
    logic [EW-1:0]   head_bits;
    entry_t          push_e;
    entry_t          head_e;

    assign num_clamped = (num_i > MAX_NUM) ? MAX_NUM : num_i;
    assign start_ok    = start_i && (state == ST_IDLE);

    assign valid = (count != 2'd0);
    assign pop   = valid && bus.mvd_ready_i;
    assign push  = rd_p1;

    // Occupancy the FIFO will reach once the read now returning has landed.
    // A read issued this cycle lands two edges later, by which time at most
    // one more pop can have happened, so occ < 2 keeps the FIFO from
    // overflowing while still allowing one read per cycle at full rate.
    // rd_o is combinational from the registered state so it reacts to this
    // cycle's pop; a registered rd_o would see the pop a cycle late and
    // could not sustain back-to-back words through a 2-deep FIFO.
    assign occ = {1'b0, count} + {2'b0, push} - {2'b0, pop};
    assign rd  = (state == ST_READ) && (occ < 3'(FIFO_DEPTH));

    assign bus.rd_o     = rd;
    assign bus.r_addr_o = addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            num_r  <= 6'd0;
            rd_cnt <= 6'd0;
            addr   <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (num_clamped == 6'd0) begin
                            done_o <= 1'b1;
                        end else begin
                            state  <= ST_READ;
                            busy_o <= 1'b1;
                            num_r  <= num_clamped;
                            rd_cnt <= 6'd0;
                            addr   <= '0;
                        end
                    end
                end
                ST_READ: begin
                    if (rd) begin
                        rd_cnt <= rd_cnt + 6'd1;
                        addr   <= addr + 1'b1;
                        if (rd_cnt == num_r - 6'd1) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && head_e.last) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // read-return stage: data_i is valid the cycle after rd_o
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_p1    <= 1'b0;
            push_cnt <= 6'd0;
        end else begin
            rd_p1 <= rd;
            if (start_ok)  push_cnt <= 6'd0;
            else if (push) push_cnt <= push_cnt + 6'd1;
        end
    end

    assign word = bus.data_i;

    always_comb begin
        push_e      = '0;
        push_e.x    = word[X_MSB:X_LSB];
        push_e.y    = word[Y_MSB:Y_LSB];
        push_e.idx  = push_cnt[AW-1:0];
        push_e.last = (push_cnt == num_r - 6'd1);
`ifdef EC_MVD_ABS_EN
        push_e.abs_x = abs_sat(word[X_MSB:X_LSB]);
        push_e.abs_y = abs_sat(word[Y_MSB:Y_LSB]);
`endif
    end

    ec_mvd_fifo2 #(
        .W (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_e),
        .count (count),
        .dout  (head_bits)
    );

    assign head_e = entry_t'(head_bits);

    // Outputs are masked with valid so an empty FIFO (including right after
    // reset) presents zeros instead of stale storage.
    assign bus.mvd_valid_o = valid;
    assign bus.mvd_x_o     = valid ? head_e.x   : '0;
    assign bus.mvd_y_o     = valid ? head_e.y   : '0;
    assign bus.mvd_idx_o   = valid ? head_e.idx : '0;
    assign bus.mvd_last_o  = valid && head_e.last;
`ifdef EC_MVD_ABS_EN
    assign bus.mvd_abs_x_o = valid ? head_e.abs_x : '0;
    assign bus.mvd_abs_y_o = valid ? head_e.abs_y : '0;
`endif

endmodule
